// File: rtl/rsa_modexp_ctrl.sv
// Left-to-right square-and-multiply sequencer for base^exp mod n.
// The modulus lives in the external multiplier; this block owns acc, the operands and the bit index.
//
// state    | meaning
// IDLE     | waiting for start; outputs hold last values
// SQR_REQ  | issue acc*acc to the multiplier
// SQR_WAIT | wait for the squaring product
// MUL_REQ  | issue acc*base to the multiplier
// MUL_WAIT | wait for the multiply product
// DONE     | one-cycle completion pulse, result valid
module rsa_modexp_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] base_in,
  input  logic [WIDTH-1:0] exp_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             mul_start,
  output logic [WIDTH-1:0] mul_a,
  output logic [WIDTH-1:0] mul_b,
  input  logic             mul_done,
  input  logic [WIDTH-1:0] mul_p
);

  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IW-1:0]    IDX_MAX = IW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

  typedef enum logic [2:0] {
    IDLE, SQR_REQ, SQR_WAIT, MUL_REQ, MUL_WAIT, DONE
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] acc, acc_nxt;
  logic [IW-1:0]    idx, idx_nxt;
  logic [WIDTH-1:0] base_q, base_nxt;
  logic [WIDTH-1:0] exp_q, exp_nxt;
  logic [WIDTH-1:0] mul_a_q, mul_b_q, result_q;

  always_comb begin
    state_nxt = state;
    acc_nxt   = acc;
    idx_nxt   = idx;
    base_nxt  = base_q;
    exp_nxt   = exp_q;
    case (state)
      IDLE: begin
        if (start && !abort) begin
          base_nxt  = base_in;
          exp_nxt   = exp_in;
          acc_nxt   = ONE;
          idx_nxt   = IDX_MAX;
          state_nxt = (exp_in == '0) ? DONE : SQR_REQ;
        end
      end
      SQR_REQ:  state_nxt = SQR_WAIT;
      SQR_WAIT: begin
        if (mul_done) begin
          acc_nxt = mul_p;
          if (exp_q[idx]) begin
            state_nxt = MUL_REQ;
          end else if (idx == '0) begin
            state_nxt = DONE;
          end else begin
            idx_nxt   = idx - 1'b1;
            state_nxt = SQR_REQ;
          end
        end
      end
      MUL_REQ:  state_nxt = MUL_WAIT;
      MUL_WAIT: begin
        if (mul_done) begin
          acc_nxt = mul_p;
          if (idx == '0) begin
            state_nxt = DONE;
          end else begin
            idx_nxt   = idx - 1'b1;
            state_nxt = SQR_REQ;
          end
        end
      end
      DONE:     state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
    // Abort beats any coincident mul_done: nothing from the abandoned op is kept.
    if (abort && state != IDLE) begin
      state_nxt = IDLE;
      acc_nxt   = acc;
      idx_nxt   = idx;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      acc      <= ONE;
      idx      <= IDX_MAX;
      base_q   <= '0;
      exp_q    <= '0;
      mul_a_q  <= '0;
      mul_b_q  <= '0;
      result_q <= '0;
    end else begin
      state  <= state_nxt;
      acc    <= acc_nxt;
      idx    <= idx_nxt;
      base_q <= base_nxt;
      exp_q  <= exp_nxt;
      // Operands load on entry to a REQ state and stay put until the next REQ.
      if (state_nxt == SQR_REQ) begin
        mul_a_q <= acc_nxt;
        mul_b_q <= acc_nxt;
      end else if (state_nxt == MUL_REQ) begin
        mul_a_q <= acc_nxt;
        mul_b_q <= base_q;
      end
      if (state_nxt == DONE) result_q <= acc_nxt;
    end
  end

  assign busy      = (state != IDLE);
  assign done      = (state == DONE);
  assign mul_start = (state == SQR_REQ) || (state == MUL_REQ);
  assign mul_a     = mul_a_q;
  assign mul_b     = mul_b_q;
  assign result    = result_q;

endmodule

// File: tb/tb_rsa_modexp_ctrl.sv
// Scoreboard bench for rsa_modexp_ctrl with a behavioural mod-187 multiplier of latency 3.
module tb_rsa_modexp_ctrl;

  localparam int W = 8;
  localparam int N = 187;
  localparam int L = 3;

  logic         clk, rst_n, start, abort;
  logic [W-1:0] base_in, exp_in;
  logic         busy, done, mul_start, mul_done;
  logic [W-1:0] result, mul_a, mul_b, mul_p;

  logic         mdl_done, spur_done, pend;
  int           cnt, prod;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int mul_cnt = 0;
  int done_cnt = 0;

  typedef struct {
    logic [W-1:0] res;
    int muls;
    int lat;
    int mc0;
    int t0;
  } sb_t;
  sb_t sb[$];
  sb_t ent;

  rsa_modexp_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .base_in(base_in), .exp_in(exp_in), .busy(busy), .done(done),
    .result(result), .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b),
    .mul_done(mul_done), .mul_p(mul_p)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // mul_done lands L cycles after the mul_start cycle
  always @(posedge clk) begin
    mdl_done <= 1'b0;
    if (pend) begin
      if (cnt == 0) begin
        mdl_done <= 1'b1;
        mul_p    <= W'(prod);
        pend     <= 1'b0;
      end else begin
        cnt <= cnt - 1;
      end
    end
    if (mul_start) begin
      pend <= 1'b1;
      cnt  <= L - 2;
      prod <= (int'(mul_a) * int'(mul_b)) % N;
    end
  end

  assign mul_done = mdl_done | spur_done;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    if (obs !== expv) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, expv);
    end
  endtask

  function automatic logic [W-1:0] ref_modexp(input logic [W-1:0] b, input logic [W-1:0] e);
    int a = 1;
    for (int i = W - 1; i >= 0; i--) begin
      a = (a * a) % N;
      if (e[i]) a = (a * int'(b)) % N;
    end
    return W'(a);
  endfunction

  always @(negedge clk) begin
    if (mul_start) mul_cnt++;
    if (done) begin
      done_cnt++;
      if (sb.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        ent = sb.pop_front();
        chk("result", result, ent.res);
        chk("mul_count", mul_cnt - ent.mc0, ent.muls);
        chk("latency", cyc - ent.t0, ent.lat);
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [W-1:0] b, input logic [W-1:0] e);
    sb_t s;
    int k;
    k = W + $countones(e);
    s.res  = ref_modexp(b, e);
    s.muls = (e == '0) ? 0 : k;
    // done is in cycle T+1+K*(L+1); both ends measured from the accepting edge
    s.lat  = (e == '0) ? 0 : k * (L + 1);
    s.mc0  = mul_cnt;
    s.t0   = cyc + 1;
    sb.push_back(s);
  endtask

  task automatic do_start(input logic [W-1:0] b, input logic [W-1:0] e, input bit push);
    step();
    base_in = b;
    exp_in  = e;
    start   = 1'b1;
    if (push) push_exp(b, e);
    step();
    start = 1'b0;
  endtask

  task automatic wait_done(input int target, input string tag);
    int i;
    for (i = 0; i < 300; i++) begin
      if (done_cnt >= target) break;
      step();
    end
    if (i == 300) chk({tag, "_timeout"}, 0, 1);
  endtask

  task automatic run_check(input logic [W-1:0] b, input logic [W-1:0] e);
    int d0;
    d0 = done_cnt;
    do_start(b, e, 1'b1);
    wait_done(d0 + 1, "run");
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_result"}, result, 0);
    chk({tag, "_mul_start"}, mul_start, 0);
    chk({tag, "_mul_a"}, mul_a, 0);
    chk({tag, "_mul_b"}, mul_b, 0);
  endtask

  initial begin
    int d0, mc0, i;
    rst_n = 0; start = 0; abort = 0; base_in = '0; exp_in = '0; spur_done = 0;
    pend = 0; cnt = 0; prod = 0; mdl_done = 0; mul_p = '0;
    repeat (3) step();
    rst_n = 1;
    step();
    chk_reset_outputs("rst");

    run_check(8'd5, 8'h03);
    run_check(8'd7, 8'h0A);
    run_check(8'd9, 8'h00);

    // abort during the 4th squaring wait; result must stay at the previous value (1)
    d0  = done_cnt;
    mc0 = mul_cnt;
    do_start(8'd5, 8'h03, 1'b0);
    for (i = 0; i < 100; i++) begin
      if (mul_cnt == mc0 + 4) break;
      step();
    end
    chk("abort_reach_sqr4", (i < 100) ? 1 : 0, 1);
    step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("abort_busy", busy, 0);
    repeat (6) step();
    chk("abort_no_done", done_cnt, d0);
    chk("abort_result", result, 1);
    chk("abort_busy_late", busy, 0);

    // start and abort together in IDLE: abort wins
    step();
    start = 1'b1; abort = 1'b1; base_in = 8'd3; exp_in = 8'h55;
    step();
    start = 1'b0; abort = 1'b0;
    chk("start_abort_idle", busy, 0);
    step();
    chk("start_abort_idle2", busy, 0);

    run_check(8'd3, 8'hFF);

    // spurious mul_done in IDLE, then start held high with changing operands
    step();
    spur_done = 1'b1;
    step();
    spur_done = 1'b0;
    chk("spur_idle_busy", busy, 0);
    d0 = done_cnt;
    step();
    base_in = 8'd11; exp_in = 8'h5A; start = 1'b1;
    push_exp(8'd11, 8'h5A);
    for (i = 0; i < 300; i++) begin
      step();
      base_in = W'($urandom);
      exp_in  = W'($urandom);
      if (done_cnt != d0) begin
        start = 1'b0;
        break;
      end
    end
    start = 1'b0;
    chk("spam_finished", (i < 300) ? 1 : 0, 1);
    repeat (10) step();
    chk("spam_one_run", done_cnt, d0 + 1);
    chk("spam_busy", busy, 0);

    // asynchronous reset mid-run
    do_start(8'd5, 8'h03, 1'b0);
    repeat (15) step();
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("midrst");
    step();
    rst_n = 1'b1;
    repeat (8) step();
    run_check(8'd5, 8'h03);

    repeat (3) step();
    chk("sb_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
